// File: rtl/op_sequencer_pkg.sv
// op_sequencer_pkg
// Shared definitions for the operation sequencer:
//   op_e            - operation select codes driven to the datapath mux
//   state_e / ST_*  - sequencer state encoding
//   encodeButtons   - priority encoder for the synchronized push-buttons
package op_sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_MULT = 3'd1,
        OP_LO   = 3'd2,
        OP_NO   = 3'd3,
        OP_ADD  = 3'd4,
        OP_SUB  = 3'd5
    } op_e;

    // Plain constants rather than an enum so the encoding stays visible
    // to older tools and netlist viewers.
    typedef logic [2:0] state_e;

    localparam state_e ST_IDLE     = 3'd0;
    localparam state_e ST_DEBOUNCE = 3'd1;
    localparam state_e ST_CAPTURE  = 3'd2;
    localparam state_e ST_SETTLE   = 3'd3;
    localparam state_e ST_RELEASE  = 3'd4;

    // Button vector is {C, U, D, L, R}; C wins over everything, R loses
    // to everything.
    function automatic op_e encodeButtons(input logic [4:0] btns);
        op_e op;
        if (btns[4]) begin
            op = OP_MULT;
        end else if (btns[3]) begin
            op = OP_LO;
        end else if (btns[2]) begin
            op = OP_NO;
        end else if (btns[1]) begin
            op = OP_ADD;
        end else if (btns[0]) begin
            op = OP_SUB;
        end else begin
            op = OP_NONE;
        end
        return op;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Each bit is synchronized on its own; no cross-bit coherence is implied.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, clears both stages
//   d_i    - raw asynchronous input
//   q_o    - synchronized output, two edges behind d_i
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage1_q;
    logic [WIDTH-1:0] stage2_q;

    // First stage may go metastable; second stage gives it a full cycle
    // to resolve before anything downstream looks at it.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            stage1_q <= d_i;
            stage2_q <= stage1_q;
        end
    end

    assign q_o = stage2_q;

endmodule

// File: rtl/op_sequencer.sv
// op_sequencer
// Front-end controller for the shared combinational datapath. Buttons and
// switches are synchronized, the button press is priority-encoded and
// debounced, the operand and operation are registered out to the datapath,
// and after the settle time the datapath result is latched onto LED.
// Ports:
//   CLK      - system clock
//   RST      - asynchronous active-high reset
//   SW       - raw switch operand
//   BTNC/U/D/L/R - raw push-buttons (C highest priority, R lowest)
//   RESULT   - datapath result for the current OP_SEL/OPERAND
//   OPERAND  - registered operand to the datapath
//   OP_SEL   - registered op_e select to the datapath mux
//   LED      - registered latched result
//   BUSY     - high whenever the sequencer is not idle
//   DONE     - one-cycle pulse coincident with a new LED value
module op_sequencer
    import op_sequencer_pkg::*;
#(
    parameter int BITS            = 16,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SETTLE_CYCLES   = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [BITS-1:0] SW,
    input  logic            BTNC,
    input  logic            BTNU,
    input  logic            BTND,
    input  logic            BTNL,
    input  logic            BTNR,
    input  logic [BITS-1:0] RESULT,
    output logic [BITS-1:0] OPERAND,
    output logic [2:0]      OP_SEL,
    output logic [BITS-1:0] LED,
    output logic            BUSY,
    output logic            DONE
);

    localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > SETTLE_CYCLES) ? DEBOUNCE_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]      rstPipe_q;
    logic            rstInt;
    logic [4:0]      btnSync;
    logic [BITS-1:0] swSync;
    op_e             curOp;

    state_e          state_q,   state_d;
    op_e             cand_q,    cand_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [BITS-1:0] operand_q, operand_d;
    op_e             opSel_q,   opSel_d;
    logic [BITS-1:0] led_q,     led_d;
    logic            done_q,    done_d;

    // Reset asserts immediately but is released only after two clean
    // edges, so no flop sees reset removal close to a clock edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rstPipe_q <= 2'b11;
        end else begin
            rstPipe_q <= {rstPipe_q[0], 1'b0};
        end
    end

    assign rstInt = rstPipe_q[1];

    sync_2ff #(.WIDTH(5)) uBtnSync (
        .clk_i (CLK),
        .rst_i (rstInt),
        .d_i   ({BTNC, BTNU, BTND, BTNL, BTNR}),
        .q_o   (btnSync)
    );

    sync_2ff #(.WIDTH(BITS)) uSwSync (
        .clk_i (CLK),
        .rst_i (rstInt),
        .d_i   (SW),
        .q_o   (swSync)
    );

    assign curOp = encodeButtons(btnSync);

    // Next-state logic. The same counter serves debounce, settle and
    // release timing since only one of them is ever active at a time.
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        operand_d = operand_q;
        opSel_d   = opSel_q;
        led_d     = led_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (curOp != OP_NONE) begin
                    cand_d  = curOp;
                    cnt_d   = '0;
                    state_d = ST_DEBOUNCE;
                end
            end

            // Any change of the encoded op, including a higher-priority
            // button joining, throws the candidate away and restarts.
            ST_DEBOUNCE: begin
                if (curOp != cand_q) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_CAPTURE: begin
                operand_d = swSync;
                opSel_d   = cand_q;
                cnt_d     = '0;
                state_d   = ST_SETTLE;
            end

            ST_SETTLE: begin
                if (cnt_q == SET_LAST) begin
                    led_d   = RESULT;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A held or bouncing button keeps us here; only a full
            // debounce period of nothing pressed re-arms the sequencer.
            ST_RELEASE: begin
                if (curOp != OP_NONE) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // All sequencer state and outputs in one register bank.
    always_ff @(posedge CLK or posedge rstInt) begin
        if (rstInt) begin
            state_q   <= ST_IDLE;
            cand_q    <= OP_NONE;
            cnt_q     <= '0;
            operand_q <= '0;
            opSel_q   <= OP_NONE;
            led_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            operand_q <= operand_d;
            opSel_q   <= opSel_d;
            led_q     <= led_d;
            done_q    <= done_d;
        end
    end

    assign OPERAND = operand_q;
    assign OP_SEL  = opSel_q;
    assign LED     = led_q;
    assign DONE    = done_q;
    assign BUSY    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_op_sequencer.sv
// tb_op_sequencer
// Self-checking bench for op_sequencer. A small datapath model drives
// RESULT from OP_SEL/OPERAND. Each scenario that should complete pushes
// its expected {op, operand, led} into a scoreboard; a monitor pops and
// compares on every DONE pulse.
module tb_op_sequencer;
    import op_sequencer_pkg::*;

    localparam int BITS = 16;
    localparam int DEB  = 4;
    localparam int SET  = 1;
    // Edge (counted from 1 at the first edge after a press) on which the
    // sequencer first sees the synchronized press.
    localparam int DETECT_EDGE = 3;
    localparam int DONE_EDGE   = DETECT_EDGE + DEB + SET + 1;
    localparam int SETTLE_EDGE = DETECT_EDGE + DEB + 1;

    typedef struct packed {
        logic [2:0]      op;
        logic [BITS-1:0] operand;
        logic [BITS-1:0] led;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [BITS-1:0] sw  = '0;
    logic [4:0]      btns = '0;
    logic [BITS-1:0] result;
    logic [BITS-1:0] operand;
    logic [2:0]      opSel;
    logic [BITS-1:0] led;
    logic            busy;
    logic            done;

    exp_t sbQ[$];
    int   checks    = 0;
    int   errors    = 0;
    int   doneCount = 0;
    logic prevDone  = 1'b0;

    op_sequencer #(
        .BITS            (BITS),
        .DEBOUNCE_CYCLES (DEB),
        .SETTLE_CYCLES   (SET)
    ) dut (
        .CLK     (clk),
        .RST     (rst),
        .SW      (sw),
        .BTNC    (btns[4]),
        .BTNU    (btns[3]),
        .BTND    (btns[2]),
        .BTNL    (btns[1]),
        .BTNR    (btns[0]),
        .RESULT  (result),
        .OPERAND (operand),
        .OP_SEL  (opSel),
        .LED     (led),
        .BUSY    (busy),
        .DONE    (done)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: what the board's combinational units compute.
    function automatic logic [BITS-1:0] dpModel(input logic [2:0] op, input logic [BITS-1:0] a);
        logic [BITS-1:0] r;
        logic            run;
        r = '0;
        case (op)
            3'd1: r = a[7:0] * a[15:8];
            3'd2: begin
                run = 1'b1;
                for (int i = BITS - 1; i >= 0; i--) begin
                    if (run && a[i]) r = r + 1'b1;
                    else run = 1'b0;
                end
            end
            3'd3: r = BITS'($countones(a));
            3'd4: r = a + 16'h1234;
            3'd5: r = a - 16'h0101;
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb result = dpModel(opSel, operand);

    // Reference priority: the first pressed button in C,U,D,L,R order wins.
    function automatic logic [2:0] refOp(input logic [4:0] b);
        logic [2:0] order [5];
        logic [2:0] r;
        order = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        r = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (r == 3'd0 && b[4 - i]) r = order[i];
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] b, input logic [BITS-1:0] s);
        @(negedge clk);
        btns = b;
        sw   = s;
    endtask

    task automatic pushExpected(input logic [2:0] op, input logic [BITS-1:0] s);
        exp_t e;
        e.op      = op;
        e.operand = s;
        e.led     = dpModel(op, s);
        sbQ.push_back(e);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic waitDone(input string name, output int n);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
        end
        checkOutput(name, done, 1'b1);
    endtask

    task automatic waitIdle(input string name);
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, busy, 1'b0);
    endtask

    // Scoreboard monitor: every DONE must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            doneCount++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedDone", 1, 0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("opSel", opSel, e.op);
                checkOutput("operand", operand, e.operand);
                checkOutput("led", led, e.led);
            end
            if (prevDone) checkOutput("donePulseWidth", 2, 1);
        end
        prevDone = done;
    end

    initial begin
        int n;
        int base;
        logic [BITS-1:0] s;
        logic [4:0]      b;

        // Reset state
        waitCycles(3);
        checkOutput("rstLed", led, 0);
        checkOutput("rstOperand", operand, 0);
        checkOutput("rstOpSel", opSel, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        rst = 1'b0;
        waitCycles(6);
        checkOutput("idleAfterRst", busy, 0);

        // Clean press with latency measurement
        base = doneCount;
        pushExpected(3'd4, 16'h0003);
        applyStimulus(5'b00010, 16'h0003);
        waitDone("cleanTimeout", n);
        checkOutput("cleanLatency", n, DONE_EDGE);
        waitCycles(5);
        checkOutput("cleanBusyHeld", busy, 1);
        applyStimulus(5'b00000, 16'h0003);
        waitIdle("cleanIdle");
        checkOutput("cleanDones", doneCount - base, 1);

        // Bouncing center button, then stable
        base = doneCount;
        s = 16'h0A0B;
        pushExpected(3'd1, s);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(5'b10000, s);
            waitCycles(1);
            applyStimulus(5'b00000, s);
            waitCycles(1);
        end
        checkOutput("bounceNoEarlyDone", doneCount - base, 0);
        applyStimulus(5'b10000, s);
        waitDone("bounceTimeout", n);
        waitCycles(4);
        applyStimulus(5'b00000, s);
        waitIdle("bounceIdle");
        checkOutput("bounceDones", doneCount - base, 1);

        // Lower-priority press joined by a higher one mid-debounce
        base = doneCount;
        s = 16'hF0F3;
        pushExpected(3'd2, s);
        applyStimulus(5'b00001, s);
        waitCycles(2);
        applyStimulus(5'b01001, s);
        waitDone("prioTimeout", n);
        waitCycles(3);
        applyStimulus(5'b00000, s);
        waitIdle("prioIdle");
        checkOutput("prioDones", doneCount - base, 1);

        // Long hold, short release glitch, then a real re-press
        base = doneCount;
        s = 16'h5A5A;
        pushExpected(3'd3, s);
        applyStimulus(5'b00100, s);
        waitCycles(50);
        applyStimulus(5'b00000, s);
        waitCycles(1);
        applyStimulus(5'b00100, s);
        waitCycles(20);
        applyStimulus(5'b00000, s);
        waitCycles(20);
        checkOutput("holdSingleDone", doneCount - base, 1);
        waitIdle("holdIdle");
        s = 16'h00FF;
        pushExpected(3'd3, s);
        applyStimulus(5'b00100, s);
        waitDone("represTimeout", n);
        applyStimulus(5'b00000, s);
        waitIdle("represIdle");
        checkOutput("represDones", doneCount - base, 2);

        // Operand captured at CAPTURE survives a switch change in SETTLE
        pushExpected(3'd4, 16'h1111);
        applyStimulus(5'b00010, 16'h1111);
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done) break;
            if (n == SETTLE_EDGE) sw = 16'hBEEF;
        end
        checkOutput("capTimeout", done, 1);
        waitCycles(4);
        checkOutput("capOperandHold", operand, 16'h1111);
        applyStimulus(5'b00000, 16'hBEEF);
        waitIdle("capIdle");

        // Reset in the middle of SETTLE
        base = doneCount;
        applyStimulus(5'b10000, 16'h7777);
        repeat (SETTLE_EDGE) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checkOutput("midRstLed", led, 0);
        checkOutput("midRstOperand", operand, 0);
        checkOutput("midRstOpSel", opSel, 0);
        checkOutput("midRstBusy", busy, 0);
        checkOutput("midRstDone", done, 0);
        waitCycles(4);
        btns = '0;
        waitCycles(2);
        rst = 1'b0;
        waitCycles(8);
        checkOutput("midRstIdle", busy, 0);
        checkOutput("midRstNoDone", doneCount - base, 0);
        checkOutput("midRstLedHeld", led, 0);

        // Randomized presses against the reference priority model
        for (int i = 0; i < 12; i++) begin
            base = doneCount;
            s = BITS'($urandom);
            b = 5'($urandom_range(1, 31));
            pushExpected(refOp(b), s);
            applyStimulus(b, s);
            waitDone("randTimeout", n);
            waitCycles($urandom_range(0, 8));
            applyStimulus(5'b00000, BITS'($urandom));
            waitIdle("randIdle");
            checkOutput("randDones", doneCount - base, 1);
        end

        waitCycles(3);
        checkOutput("scoreboardEmpty", sbQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/op_sequencer.md
# op_sequencer

Sequential front-end controller for the board's shared combinational datapath (multiplier, leading-ones, ones-count, adder, subtractor). It synchronizes and debounces the five push-buttons and captures the switch operand. It then drives a one-hot-free encoded operation select into the datapath, waits for the result to settle, and latches it into a registered LED output. It sits between the board pins and the datapath, replacing direct button-to-mux wiring.

## Interface
- BITS, 16, operand/result width
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required for press and release (≥2; board build overrides to ~1_000_000)
- SETTLE_CYCLES, 1, cycles allowed for datapath to settle after OP_SEL/OPERAND change (≥1)

Ports:
- CLK  in  1  system clock; single clock domain
- RST  in  1  reset, asynchronous, active-high
- SW  in  BITS  raw switch operand
- BTNC, BTNU, BTND, BTNL, BTNR  in  1 each  raw push-buttons
- RESULT  in  BITS  datapath result for current OP_SEL/OPERAND, zero-extended by datapath
- OPERAND  out  BITS  registered operand to datapath
- OP_SEL  out  3  registered op_e to datapath mux
- LED  out  BITS  registered latched result
- BUSY  out  1  high in every state except IDLE
- DONE  out  1  one-cycle pulse when LED is updated

## Operation
- All raw inputs (SW, buttons) pass through 2-flop synchronizers; only synchronized values are used.
- Priority encode of synced buttons: C→OP_MULT, U→OP_LO, D→OP_NO, L→OP_ADD, R→OP_SUB, none→OP_NONE; C highest, R lowest.
- States: IDLE, DEBOUNCE, CAPTURE, SETTLE, RELEASE.
- IDLE: if encoded op ≠ OP_NONE, cand←op, cnt←0, go DEBOUNCE.
- DEBOUNCE: each cycle, if op≠cand go IDLE; else cnt++. On the cycle cnt==DEBOUNCE_CYCLES-1 with op==cand, go CAPTURE. Total of DEBOUNCE_CYCLES matching cycles.
- CAPTURE (1 cycle): OPERAND←synced SW, OP_SEL←cand, cnt←0, go SETTLE.
- SETTLE: SETTLE_CYCLES cycles. On the last one LED←RESULT, DONE←1, cnt←0, go RELEASE.
- RELEASE: cnt counts consecutive cycles with op==OP_NONE and resets to 0 on any press. At DEBOUNCE_CYCLES go IDLE.
- Buttons changing during CAPTURE/SETTLE are ignored. A higher-priority button arriving during DEBOUNCE changes op, so the block restarts via IDLE.
- OPERAND, OP_SEL and LED hold their last values until the next CAPTURE/SETTLE; OP_SEL is never returned to OP_NONE except by reset.
- cnt width: $clog2(max(DEBOUNCE_CYCLES,SETTLE_CYCLES))+1; no wrap possible.

## Timing
- Reset (async assert, sync-safe deassert inside block): state IDLE; OPERAND=0, OP_SEL=OP_NONE, LED=0, BUSY=0, DONE=0; synchronizers and cnt cleared.
- Reset mid-operation aborts immediately. No LED update occurs and DONE is not pulsed.
- Latency: pin-to-sync is 2 edges. If IDLE detects at edge k, CAPTURE occurs at edge k+DEBOUNCE_CYCLES+1, and LED/DONE update at edge k+DEBOUNCE_CYCLES+SETTLE_CYCLES+1. Defaults give k+6.
- DONE high exactly one cycle, coincident with the new LED value.
- Minimum time between two completed operations: DONE to next DONE ≥ 2·DEBOUNCE_CYCLES+SETTLE_CYCLES+2 cycles.

## Structure
- op_sequencer_pkg: op_e (OP_NONE=0, OP_MULT=1, OP_LO=2, OP_NO=3, OP_ADD=4, OP_SUB=5), state_e, priority-encode function.
- Sub-module sync_2ff (parameter WIDTH): two-flop synchronizer with async active-high reset, instantiated once for {buttons} and once for SW.
- Single always_ff FSM + counter; outputs registered, no combinational paths from inputs to outputs.

## Test plan
- Reset: assert RST mid-SETTLE → all outputs 0, OP_SEL=OP_NONE, DONE never pulses; after release, state IDLE.
- Clean press: SW=16'h0003, hold BTNL with RESULT model SW+const → OP_SEL=OP_ADD. LED=model value exactly DEBOUNCE_CYCLES+SETTLE_CYCLES+1 edges after detect; single DONE.
- Bounce: BTNC toggles every 2 cycles for 20 cycles, then stable → no CAPTURE until DEBOUNCE_CYCLES stable cycles; exactly one DONE, OP_SEL=OP_MULT.
- Priority/restart: BTNR pressed, BTNU added during DEBOUNCE → restart; final OP_SEL=OP_LO, one DONE.
- Hold and re-press: keep BTND held 50 cycles → one DONE only. Release <DEBOUNCE_CYCLES, re-press → no new op. Full release, then press → second DONE.
- Operand capture: SW changes during SETTLE → OPERAND keeps the value captured at CAPTURE, and LED reflects it.
